free_list: RTL and testbench
============================

// Module: free_list
// PURPOSE
// Banked physical-register free list. Receives PRs released by the ROB PR free queue at commit and hands free
// PRs to rename, up to one per bank per cycle. It is the consumer end of the ROB's PR free path and the producer
// of new destination PRs for the decode/rename stage. There is one circular FIFO per PRF bank, so allocated PRs
// spread evenly across PRF write banks.
// PARAMETERS
// PR_COUNT           128  total physical registers; pr_t = $clog2(PR_COUNT) bits
// BANK_COUNT         4    banks / FIFOs; bank = pr[LOG_BANK-1:0], upper = pr[LOG_PR-1:LOG_BANK]
// INIT_MAPPED_COUNT  64   PRs 0..63 are owned by the reset map table (x0-x31, f0-f31); the rest start free
// PORTS
// CLK                     in   1       clock
// RST                     in   1       synchronous reset, active-high
// enq_valid_by_bank       in   4       freed PR arriving for bank b this cycle
// enq_pr_by_bank          in   4x7     freed pr_t per bank; pr[1:0] must equal b
// deq_req_valid_by_lane   in   4       rename lane i needs a new PR
// deq_req_ready           out  1       every requesting lane is served this cycle (all-or-nothing)
// deq_pr_by_lane          out  4x7     PR granted to lane i; valid only when deq_req_valid[i] && deq_req_ready
// free_cnt                out  8       total free PRs, 0..128
// BEHAVIOUR
// - Per bank: storage of PR_COUNT/BANK_COUNT (32) upper_pr_t entries, 5b head/tail pointers that wrap mod 32,
//   and a 6b count (0..32).
// - Reset: bank b holds upper values 16..31 in order, so the heads are 16, count = 16, tail = 0 (wrapped),
//   rr_ptr = 0, free_cnt = 64. Any operation in progress is dropped.
// - Bank assignment is combinational: let k = popcount(deq_req_valid_by_lane). The j-th requesting lane
//   (ascending i, j = 0..k-1) is assigned bank (rr_ptr + j) mod 4.
//   - deq_pr_by_lane[i] = {head entry of the assigned bank, bank index}.
//   - Non-requesting lanes output 0.
// - deq_req_ready = 1 iff every assigned bank has count != 0. It is 1 when k = 0.
// - Fire = (k != 0) && deq_req_ready. On fire:
//   - each assigned bank advances its head by 1 and decrements its count;
//   - rr_ptr <= (rr_ptr + k) mod 4.
//   With no fire, there are no state changes; outputs simply reflect current heads.
// - Enqueue: when enq_valid_by_bank[b] is set, write upper(enq_pr_by_bank[b]) at tail, then increment tail
//   and count. All 4 banks can enqueue in parallel.
// - A same-cycle enqueue and dequeue on one bank moves both pointers and leaves count unchanged.
// - There is no bypass. A PR enqueued in cycle t is dequeueable no earlier than t+1. An empty bank that is
//   receiving an enqueue still drives ready = 0.
// - Overflow is impossible by construction because PRs are conserved. Assertions must flag:
//   - enq when count == 32;
//   - a bank mismatch on enq_pr_by_bank;
//   - a dequeue when count == 0.
// - free_cnt is registered and equals the sum of the bank counts after the edge. It is a 1-cycle-accurate
//   view, not a prediction.
// - Request inputs need not be stable when deq_req_ready = 0. Rename re-presents them next cycle.
// - Single cycle latency: grant is combinational from registered heads; state updates at the next CLK edge.
// TESTING
// - Reset, then request all 4 lanes -> ready = 1, PRs = 64, 65, 66, 67. Next cycle, all 4 lanes again ->
//   68, 69, 70, 71. free_cnt 64 -> 60 -> 56.
// - After reset, lanes {1,3} request -> lane1 = 64 (bank0), lane3 = 65 (bank1), rr_ptr = 2. Then lane0 alone
//   -> 66 (bank2).
// - Drain bank0 (16 grants) while other banks still have entries. The next request set whose assignment
//   includes bank0 -> ready = 0, and no pointer or count changes occur.
// - On bank0 empty, enq pr 0x04 with a request assigned to bank0 in the same cycle -> ready = 0. Next cycle
//   -> ready = 1 and PR = 0x04.
// - Simultaneous enq and deq on all banks for 40 cycles -> counts constant, pointers wrap past 31 cleanly,
//   and the granted PR order matches the enqueue order per bank.
// - Assert RST mid-stream with partial counts -> next cycle, state matches the reset image (free_cnt = 64,
//   first grant = 64).

Source files
------------

// File: rtl/free_list.sv
// Banked physical-register free list: one circular FIFO per PRF bank, fed by committed
// releases and drained by rename, with all-or-nothing round-robin bank assignment per cycle.
module free_list #(
    parameter int unsigned PR_COUNT          = 128,
    parameter int unsigned BANK_COUNT        = 4,
    parameter int unsigned INIT_MAPPED_COUNT = 64,
    localparam int unsigned LOG_PR           = $clog2(PR_COUNT),
    localparam int unsigned CNT_W            = $clog2(PR_COUNT + 1)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [BANK_COUNT-1:0]        enq_valid_by_bank,
    input  logic [BANK_COUNT*LOG_PR-1:0] enq_pr_by_bank,
    input  logic [BANK_COUNT-1:0]        deq_req_valid_by_lane,
    output logic                         deq_req_ready,
    output logic [BANK_COUNT*LOG_PR-1:0] deq_pr_by_lane,
    output logic [CNT_W-1:0]             free_cnt
);

    localparam int unsigned LOG_BANK  = $clog2(BANK_COUNT);
    localparam int unsigned DEPTH     = PR_COUNT / BANK_COUNT;
    localparam int unsigned LOG_DEPTH = $clog2(DEPTH);
    localparam int unsigned UPPER_W   = LOG_PR - LOG_BANK;
    localparam int unsigned CW        = LOG_DEPTH + 1;
    localparam int unsigned INIT_HEAD = INIT_MAPPED_COUNT / BANK_COUNT;
    localparam int unsigned INIT_FREE = DEPTH - INIT_HEAD;

    logic [UPPER_W-1:0]   mem_q  [BANK_COUNT][DEPTH];
    logic [LOG_DEPTH-1:0] head_q [BANK_COUNT];
    logic [LOG_DEPTH-1:0] tail_q [BANK_COUNT];
    logic [CW-1:0]        cnt_q  [BANK_COUNT];
    logic [CW-1:0]        cnt_d  [BANK_COUNT];
    logic [LOG_BANK-1:0]  rr_q;
    logic [BANK_COUNT-1:0] bank_sel;
    logic [LOG_BANK-1:0]  cur_bank;
    logic [LOG_BANK:0]    req_cnt;
    logic                 fire;
    logic [CNT_W-1:0]     free_sum;

    // Requesting lanes take consecutive banks starting at rr_q, so assigned banks never collide.
    always_comb begin
        bank_sel       = '0;
        deq_pr_by_lane = '0;
        req_cnt        = '0;
        cur_bank       = '0;
        deq_req_ready  = 1'b1;
        for (int i = 0; i < int'(BANK_COUNT); i++) begin
            if (deq_req_valid_by_lane[i]) begin
                cur_bank = rr_q + req_cnt[LOG_BANK-1:0];
                bank_sel[cur_bank] = 1'b1;
                deq_pr_by_lane[i*LOG_PR +: LOG_PR] = {mem_q[cur_bank][head_q[cur_bank]], cur_bank};
                if (cnt_q[cur_bank] == '0) begin
                    deq_req_ready = 1'b0;
                end
                req_cnt = req_cnt + 1'b1;
            end
        end
        fire = (req_cnt != '0) && deq_req_ready;
    end

    always_comb begin
        free_sum = '0;
        for (int b = 0; b < int'(BANK_COUNT); b++) begin
            cnt_d[b] = cnt_q[b] + CW'(enq_valid_by_bank[b]) - CW'(fire & bank_sel[b]);
            free_sum = free_sum + CNT_W'(cnt_d[b]);
        end
    end

    // Reset image: entry e holds upper value e, so the free region 16..31 is already in order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int b = 0; b < int'(BANK_COUNT); b++) begin
                for (int e = 0; e < int'(DEPTH); e++) begin
                    mem_q[b][e] <= UPPER_W'(e);
                end
                head_q[b] <= LOG_DEPTH'(INIT_HEAD);
                tail_q[b] <= LOG_DEPTH'(INIT_HEAD + INIT_FREE);
                cnt_q[b]  <= CW'(INIT_FREE);
            end
            rr_q     <= '0;
            free_cnt <= CNT_W'(INIT_FREE * BANK_COUNT);
        end else begin
            for (int b = 0; b < int'(BANK_COUNT); b++) begin
                if (enq_valid_by_bank[b]) begin
                    mem_q[b][tail_q[b]] <= enq_pr_by_bank[b*LOG_PR + LOG_BANK +: UPPER_W];
                    tail_q[b] <= tail_q[b] + 1'b1;
                end
                if (fire && bank_sel[b]) begin
                    head_q[b] <= head_q[b] + 1'b1;
                end
                cnt_q[b] <= cnt_d[b];
            end
            if (fire) begin
                rr_q <= rr_q + req_cnt[LOG_BANK-1:0];
            end
            free_cnt <= free_sum;
        end
    end

    for (genvar b = 0; b < int'(BANK_COUNT); b++) begin : g_chk
        a_enq_full : assert property (@(posedge CLK) disable iff (RST)
            enq_valid_by_bank[b] |-> cnt_q[b] != CW'(DEPTH));
        a_enq_bank : assert property (@(posedge CLK) disable iff (RST)
            enq_valid_by_bank[b] |-> enq_pr_by_bank[b*LOG_PR +: LOG_BANK] == LOG_BANK'(b));
        a_deq_empty : assert property (@(posedge CLK) disable iff (RST)
            (fire && bank_sel[b]) |-> cnt_q[b] != '0);
    end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: per-bank queue reference model, directed spec scenarios
// and randomized request/release traffic.
module tb_free_list;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  enq_valid_by_bank = '0;
    logic [27:0] enq_pr_by_bank = '0;
    logic [3:0]  deq_req_valid_by_lane = '0;
    logic        deq_req_ready;
    logic [27:0] deq_pr_by_lane;
    logic [7:0]  free_cnt;

    always #5 CLK = ~CLK;

    free_list dut (
        .CLK                   (CLK),
        .RST                   (RST),
        .enq_valid_by_bank     (enq_valid_by_bank),
        .enq_pr_by_bank        (enq_pr_by_bank),
        .deq_req_valid_by_lane (deq_req_valid_by_lane),
        .deq_req_ready         (deq_req_ready),
        .deq_pr_by_lane        (deq_pr_by_lane),
        .free_cnt              (free_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Model: free PRs per bank in grant order, PRs held by the machine per bank, round-robin start.
    int q[4][$];
    int held[4][$];
    int rr;

    logic [3:0]  env;
    logic [27:0] epr;
    logic        obs_ready;
    logic [27:0] obs_pr;
    logic [7:0]  obs_free;
    logic        exp_ready;
    int          exp_pr[4];
    logic [3:0]  exp_chk;
    int          exp_free;

    function automatic void model_reset();
        for (int b = 0; b < 4; b++) begin
            q[b].delete();
            held[b].delete();
            for (int u = 16; u < 32; u++) q[b].push_back(u * 4 + b);
            for (int u = 0; u < 16; u++) held[b].push_back(u * 4 + b);
        end
        rr = 0;
    endfunction

    // Release random held PRs on the masked banks (only PRs the machine owns, so no overflow).
    task automatic pick_enq(input logic [3:0] mask, input int pct);
        env = '0;
        epr = '0;
        for (int b = 0; b < 4; b++) begin
            if (mask[b] && held[b].size() != 0 && int'($urandom_range(99)) < pct) begin
                int idx;
                idx = int'($urandom_range(held[b].size() - 1));
                epr[b*7 +: 7] = 7'(held[b][idx]);
                held[b].delete(idx);
                env[b] = 1'b1;
            end
        end
    endtask

    task automatic step(input logic [3:0] req);
        int k;
        int asg[4];
        @(negedge CLK);
        deq_req_valid_by_lane = req;
        enq_valid_by_bank = env;
        enq_pr_by_bank = epr;
        #1;
        obs_ready = deq_req_ready;
        obs_pr = deq_pr_by_lane;
        k = 0;
        exp_ready = 1'b1;
        exp_chk = 4'hF;
        for (int i = 0; i < 4; i++) begin
            exp_pr[i] = 0;
            asg[i] = 0;
            if (req[i]) begin
                asg[i] = (rr + k) % 4;
                k++;
                if (q[asg[i]].size() == 0) exp_ready = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
                if (exp_ready) exp_pr[i] = q[asg[i]][0];
                else exp_chk[i] = 1'b0;
            end
        end
        @(posedge CLK);
        if (k != 0 && exp_ready) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) held[asg[i]].push_back(q[asg[i]].pop_front());
            end
            rr = (rr + k) % 4;
        end
        for (int b = 0; b < 4; b++) begin
            if (env[b]) q[b].push_back(int'(epr[b*7 +: 7]));
        end
        #1;
        obs_free = free_cnt;
        exp_free = 0;
        for (int b = 0; b < 4; b++) exp_free += q[b].size();
        env = '0;
        epr = '0;
    endtask

    task automatic do_reset(input logic [3:0] req, input logic [3:0] ev, input logic [27:0] pr);
        @(negedge CLK);
        RST = 1'b1;
        deq_req_valid_by_lane = req;
        enq_valid_by_bank = ev;
        enq_pr_by_bank = pr;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        deq_req_valid_by_lane = '0;
        enq_valid_by_bank = '0;
        enq_pr_by_bank = '0;
        model_reset();
        env = '0;
        epr = '0;
    endtask

    task automatic test_reset();
        do_reset(4'h0, 4'h0, 28'h0);
        #1;
        checks++;
        if (free_cnt !== 8'd64) begin
            failures++;
            $display("FAIL reset_free_cnt got=%0d exp=64", free_cnt);
        end
        checks++;
        if (deq_req_ready !== 1'b1 || deq_pr_by_lane !== 28'h0) begin
            failures++;
            $display("FAIL reset_idle got ready=%0b pr=%h exp ready=1 pr=0", deq_req_ready,
                     deq_pr_by_lane);
        end
        step(4'h0);
        checks++;
        if (obs_ready !== 1'b1 || obs_free !== 8'(exp_free)) begin
            failures++;
            $display("FAIL reset_no_req got ready=%0b free=%0d exp ready=1 free=%0d", obs_ready,
                     obs_free, exp_free);
        end
    endtask

    task automatic test_all_lanes();
        int base;
        do_reset(4'h0, 4'h0, 28'h0);
        for (int c = 0; c < 2; c++) begin
            base = 64 + 4 * c;
            step(4'hF);
            checks++;
            if (obs_ready !== 1'b1) begin
                failures++;
                $display("FAIL all_lanes_ready c%0d got=%0b exp=1", c, obs_ready);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_pr[i*7 +: 7] !== 7'(base + i) || obs_pr[i*7 +: 7] !== 7'(exp_pr[i])) begin
                    failures++;
                    $display("FAIL all_lanes_pr c%0d lane%0d got=%0d exp=%0d", c, i,
                             obs_pr[i*7 +: 7], base + i);
                end
            end
            checks++;
            if (obs_free !== 8'(60 - 4 * c)) begin
                failures++;
                $display("FAIL all_lanes_free c%0d got=%0d exp=%0d", c, obs_free, 60 - 4 * c);
            end
        end
    endtask

    task automatic test_sparse();
        do_reset(4'h0, 4'h0, 28'h0);
        step(4'b1010);
        checks++;
        if (obs_ready !== 1'b1 || obs_pr[7 +: 7] !== 7'd64 || obs_pr[21 +: 7] !== 7'd65 ||
            obs_pr[0 +: 7] !== 7'd0 || obs_pr[14 +: 7] !== 7'd0) begin
            failures++;
            $display("FAIL sparse_1_3 got ready=%0b pr=%h exp lane1=64 lane3=65 others=0",
                     obs_ready, obs_pr);
        end
        step(4'b0001);
        checks++;
        if (obs_ready !== 1'b1 || obs_pr[0 +: 7] !== 7'd66) begin
            failures++;
            $display("FAIL sparse_lane0 got ready=%0b pr=%0d exp ready=1 pr=66", obs_ready,
                     obs_pr[0 +: 7]);
        end
        checks++;
        if (obs_free !== 8'd61) begin
            failures++;
            $display("FAIL sparse_free got=%0d exp=61", obs_free);
        end
    endtask

    // Drains bank0 while topping up banks 1..3, then probes the empty-bank stall.
    task automatic test_drain_and_enq_empty();
        int fails_before;
        do_reset(4'h0, 4'h0, 28'h0);
        fails_before = failures;
        for (int c = 0; c < 16; c++) begin
            pick_enq(4'b1110, 100);
            step(4'hF);
            checks++;
            if (obs_ready !== exp_ready || obs_free !== 8'(exp_free)) begin
                failures++;
                $display("FAIL drain c%0d got ready=%0b free=%0d exp ready=%0b free=%0d", c,
                         obs_ready, obs_free, exp_ready, exp_free);
            end
        end
        step(4'hF);
        checks++;
        if (obs_ready !== 1'b0 || obs_free !== 8'd48 || obs_free !== 8'(exp_free)) begin
            failures++;
            $display("FAIL drain_stall got ready=%0b free=%0d exp ready=0 free=48", obs_ready,
                     obs_free);
        end
        // rr is back at 0, so lane0 alone targets the empty bank0.
        for (int i = 0; i < held[0].size(); i++) begin
            if (held[0][i] == 4) begin
                held[0].delete(i);
                break;
            end
        end
        env = 4'b0001;
        epr = 28'h4;
        step(4'b0001);
        checks++;
        if (obs_ready !== 1'b0) begin
            failures++;
            $display("FAIL enq_empty_same_cycle got ready=%0b exp=0", obs_ready);
        end
        step(4'b0001);
        checks++;
        if (obs_ready !== 1'b1 || obs_pr[0 +: 7] !== 7'h04) begin
            failures++;
            $display("FAIL enq_empty_next got ready=%0b pr=%0d exp ready=1 pr=4", obs_ready,
                     obs_pr[0 +: 7]);
        end
        checks++;
        if (obs_free !== 8'(exp_free)) begin
            failures++;
            $display("FAIL enq_empty_free got=%0d exp=%0d", obs_free, exp_free);
        end
    endtask

    task automatic test_wrap();
        do_reset(4'h0, 4'h0, 28'h0);
        for (int c = 0; c < 40; c++) begin
            pick_enq(4'hF, 100);
            step(4'hF);
            checks++;
            if (obs_ready !== 1'b1 || obs_free !== 8'd64) begin
                failures++;
                $display("FAIL wrap c%0d got ready=%0b free=%0d exp ready=1 free=64", c,
                         obs_ready, obs_free);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_pr[i*7 +: 7] !== 7'(exp_pr[i])) begin
                    failures++;
                    $display("FAIL wrap_pr c%0d lane%0d got=%0d exp=%0d", c, i,
                             obs_pr[i*7 +: 7], exp_pr[i]);
                end
            end
        end
    endtask

    task automatic test_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            pick_enq(4'hF, 40);
            step(4'($urandom_range(15)));
            checks++;
            if (obs_ready !== exp_ready || obs_free !== 8'(exp_free)) begin
                failures++;
                $display("FAIL rand c%0d got ready=%0b free=%0d exp ready=%0b free=%0d", c,
                         obs_ready, obs_free, exp_ready, exp_free);
            end
            for (int i = 0; i < 4; i++) begin
                if (exp_chk[i]) begin
                    checks++;
                    if (obs_pr[i*7 +: 7] !== 7'(exp_pr[i])) begin
                        failures++;
                        $display("FAIL rand_pr c%0d lane%0d got=%0d exp=%0d", c, i,
                                 obs_pr[i*7 +: 7], exp_pr[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        test_random(30);
        pick_enq(4'hF, 100);
        do_reset(4'hF, env, epr);
        step(4'hF);
        checks++;
        if (obs_ready !== 1'b1 || obs_pr[0 +: 7] !== 7'd64 || obs_pr[21 +: 7] !== 7'd67) begin
            failures++;
            $display("FAIL mid_reset_grant got ready=%0b lane0=%0d lane3=%0d exp 1/64/67",
                     obs_ready, obs_pr[0 +: 7], obs_pr[21 +: 7]);
        end
        checks++;
        if (obs_free !== 8'd60) begin
            failures++;
            $display("FAIL mid_reset_free got=%0d exp=60", obs_free);
        end
    endtask

    initial begin
        env = '0;
        epr = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        test_reset();
        test_all_lanes();
        test_sparse();
        test_drain_and_enq_empty();
        test_wrap();
        do_reset(4'h0, 4'h0, 28'h0);
        test_random(400);
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
